fifo_stream_ctrl: RTL and testbench

FIFO_STREAM_CTRL -- requirements
Module: fifo_stream_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 20 ++
 rtl/fifo_obuf2.sv | 64 ++++++
 rtl/fifo_stream_ctrl.sv | 154 +++++++++++++++
 tb/tb_fifo_stream_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the stream-to-FIFO controller: default payload
// width, FIFO array depth, pointer/counter widths and the controller state
// encoding.
// ---------------------------------------------------------------------------
package fifo_ctrl_pkg;

    localparam int DATA_W = 9;
    localparam int DEPTH  = 256;
    localparam int PTR_W  = 8;
    localparam int CNT_W  = 9;

    typedef enum logic [1:0] {
        CLR   = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_obuf2.sv
// ---------------------------------------------------------------------------
// fifo_obuf2
// Two-entry in-order output buffer sitting behind the FIFO's registered read
// port. Entry 0 is always the head.
//
// Ports
//   clk, rst         clock, synchronous active-high reset (occupancy only)
//   clr              discard all entries
//   push, push_data  capture one word into the tail
//   pop              remove the head word (only when occ != 0)
//   occ              number of valid entries (0..2)
//   head             head entry data (meaningful only when occ != 0)
// ---------------------------------------------------------------------------
module fifo_obuf2 #(
    parameter int DATA_W = fifo_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic [1:0]        occ_r;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            occ_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Data entries carry no reset; occ_r qualifies them.
    always_ff @(posedge clk) begin
        if (pop) begin
            // Shift toward the head; a word pushed while popping a single
            // entry goes straight into the head slot.
            ent0 <= (push && occ_r == 2'd1) ? push_data : ent1;
            if (push) begin
                ent1 <= push_data;
            end
        end else if (push) begin
            if (occ_r == 2'd0) begin
                ent0 <= push_data;
            end else begin
                ent1 <= push_data;
            end
        end
    end

    assign occ  = occ_r;
    assign head = ent0;

endmodule

// File: rtl/fifo_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_stream_ctrl
// Valid/ready stream wrapper around an external single-clock FIFO array with
// a registered read port. Writes go straight into the array; reads are issued
// ahead and their data (available one cycle later) lands in a 2-entry output
// buffer that drives the downstream stream.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard all stored and in-flight words
//   s_valid, s_data, s_ready upstream write stream
//   m_valid, m_data, m_ready downstream read stream
//   fifo_wren, fifo_wrinc    FIFO write strobe / write-pointer increment
//   fifo_rden, fifo_rdinc    FIFO read strobe / read-pointer increment
//   fifo_wrptrclr/rdptrclr   FIFO pointer clears
//   fifo_din                 FIFO write data
//   fifo_dout                FIFO registered read data
//   count                    words held: array + in-flight read + buffered
//   full, empty              array full / nothing held anywhere
// ---------------------------------------------------------------------------
module fifo_stream_ctrl #(
    parameter int DATA_W = fifo_ctrl_pkg::DATA_W,
    parameter int DEPTH  = fifo_ctrl_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       s_ready,
    output logic                       m_valid,
    output logic [DATA_W-1:0]          m_data,
    input  logic                       m_ready,
    output logic                       fifo_wren,
    output logic                       fifo_wrinc,
    output logic                       fifo_rden,
    output logic                       fifo_rdinc,
    output logic                       fifo_wrptrclr,
    output logic                       fifo_rdptrclr,
    output logic [DATA_W-1:0]          fifo_din,
    input  logic [DATA_W-1:0]          fifo_dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    import fifo_ctrl_pkg::*;

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic              run;
    logic              ptrclr;
    logic              flush_go;
    logic              accept;
    logic              rd_issue;
    logic              pop;
    logic [2:0]        busy;
    logic [CW-1:0]     mem_cnt;
    logic              rd_pend;
    logic [1:0]        occ;
    logic [DATA_W-1:0] head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR;
        end else begin
            state <= state_nxt;
        end
    end

    // CLR and FLUSH are single-cycle pointer-clear states; only RUN moves data.
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        ptrclr    = 1'b1;
        case (state)
            CLR:   state_nxt = RUN;
            RUN: begin
                ptrclr = 1'b0;
                run    = !flush;
                if (flush) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: state_nxt = RUN;
            default: state_nxt = CLR;
        endcase
        if (rst) begin
            run    = 1'b0;
            ptrclr = 1'b1;
        end
    end

    assign flush_go = (state == RUN) && flush;

    assign s_ready = run && (mem_cnt < DEPTH_C);
    assign accept  = s_valid && s_ready;

    assign m_valid = (occ != 2'd0) && !rst;
    assign pop     = m_valid && m_ready;

    // Buffer slots still claimed after this cycle. Counting the pop as freed
    // space lets a read issue every cycle while the consumer keeps up, and
    // still guarantees a free slot when the read data lands a cycle later.
    assign busy     = 3'(occ) + 3'(rd_pend) - 3'(pop);
    assign rd_issue = run && (mem_cnt != '0) && (busy < 3'd2);

    // Stage 0 -> 1: array occupancy and read-in-flight flag.
    always_ff @(posedge clk) begin
        if (rst || flush_go) begin
            mem_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            if (accept && !rd_issue) begin
                mem_cnt <= mem_cnt + 1'b1;
            end else if (!accept && rd_issue) begin
                mem_cnt <= mem_cnt - 1'b1;
            end
        end
    end

    // Stage 1 -> 2: registered FIFO read data captured into the output buffer.
    fifo_obuf2 #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush_go),
        .push      (rd_pend),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign m_data = m_valid ? head : '0;

    assign fifo_wren     = accept;
    assign fifo_wrinc    = accept;
    assign fifo_din      = s_data;
    assign fifo_rden     = rd_issue;
    assign fifo_rdinc    = rd_issue;
    assign fifo_wrptrclr = ptrclr;
    assign fifo_rdptrclr = ptrclr;

    assign count = mem_cnt + CW'(rd_pend) + CW'(occ);
    assign full  = (mem_cnt == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_ctrl
// Bench for fifo_stream_ctrl with a behavioural 256x9 FIFO peer and a queue
// reference model of the words accepted but not yet delivered.
// ---------------------------------------------------------------------------
module tb_fifo_stream_ctrl;

    localparam int DW    = 9;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          fifo_wren, fifo_wrinc, fifo_rden, fifo_rdinc;
    logic          fifo_wrptrclr, fifo_rdptrclr;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout;
    logic [8:0]    count;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    fifo_stream_ctrl #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .fifo_wren     (fifo_wren),
        .fifo_wrinc    (fifo_wrinc),
        .fifo_rden     (fifo_rden),
        .fifo_rdinc    (fifo_rdinc),
        .fifo_wrptrclr (fifo_wrptrclr),
        .fifo_rdptrclr (fifo_rdptrclr),
        .fifo_din      (fifo_din),
        .fifo_dout     (fifo_dout),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    // Peer: 256x9 FIFO array with registered read data and pointer controls.
    logic [DW-1:0] mem [DEPTH];
    logic [7:0]    wp;
    logic [7:0]    rp;

    always @(posedge clk) begin
        if (fifo_wren) mem[wp] <= fifo_din;
        if (fifo_wrptrclr) wp <= 8'd0;
        else if (fifo_wrinc) wp <= wp + 8'd1;
        if (fifo_rden) fifo_dout <= mem[rp];
        if (fifo_rdptrclr) rp <= 8'd0;
        else if (fifo_rdinc) rp <= rp + 8'd1;
    end

    int tests   = 0;
    int fails   = 0;
    int cyc_cnt = 0;
    int pop_cnt = 0;
    logic [DW-1:0] q [$];

    // Sample just before the coming edge, compare against the model, then
    // apply that edge's handshakes to the model.
    task automatic cyc_neg();
        @(negedge clk);
        cyc_cnt++;
        if (!rst) begin
            tests++;
            if (int'(count) != q.size()) begin
                fails++;
                $display("FAIL model_count: got %0d want %0d (cycle %0d)", count, q.size(), cyc_cnt);
            end
            tests++;
            if (empty !== (q.size() == 0)) begin
                fails++;
                $display("FAIL model_empty: got %0b want %0b", empty, (q.size() == 0));
            end
            if (m_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stale_word: got m_valid=1 m_data=%0h want no word", m_data);
                end else if (m_data !== q[0]) begin
                    fails++;
                    $display("FAIL out_order: got %0h want %0h (cycle %0d)", m_data, q[0], cyc_cnt);
                end
            end
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            if (s_valid && s_ready) q.push_back(s_data);
            if (m_valid && m_ready) begin
                pop_cnt++;
                if (q.size() > 0) void'(q.pop_front());
            end
        end
    endtask

    task automatic cyc_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cyc_neg();
        cyc_pos();
    endtask

    task automatic traffic(input int n, input int vpct, input int rpct, input int fpct);
        for (int i = 0; i < n; i++) begin
            s_valid = ($urandom_range(0, 99) < vpct);
            s_data  = DW'($urandom);
            m_ready = ($urandom_range(0, 99) < rpct);
            flush   = ($urandom_range(0, 999) < fpct);
            step();
        end
        s_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic drain();
        int n;
        s_valid = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 2000) begin
            step();
            n++;
        end
        step();
        tests++;
        if (q.size() != 0 || count !== 9'd0) begin
            fails++;
            $display("FAIL drain: got model=%0d count=%0d want 0/0", q.size(), count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step();
        cyc_neg();
        tests++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 9'd0) begin
            fails++;
            $display("FAIL rst_stream: got s_ready=%0b m_valid=%0b m_data=%0h want 0/0/0", s_ready, m_valid, m_data);
        end
        tests++;
        if (fifo_wren !== 1'b0 || fifo_wrinc !== 1'b0 || fifo_rden !== 1'b0 || fifo_rdinc !== 1'b0) begin
            fails++;
            $display("FAIL rst_ctrl: got wren=%0b wrinc=%0b rden=%0b rdinc=%0b want 0", fifo_wren, fifo_wrinc, fifo_rden, fifo_rdinc);
        end
        tests++;
        if (count !== 9'd0 || full !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL rst_status: got count=%0d full=%0b empty=%0b want 0/0/1", count, full, empty);
        end
        cyc_pos();
        rst = 1'b0;
        cyc_neg();
        tests++;
        if (fifo_wrptrclr !== 1'b1 || fifo_rdptrclr !== 1'b1 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_cycle: got wrclr=%0b rdclr=%0b s_ready=%0b want 1/1/0", fifo_wrptrclr, fifo_rdptrclr, s_ready);
        end
        cyc_pos();
        cyc_neg();
        tests++;
        if (fifo_wrptrclr !== 1'b0 || fifo_rdptrclr !== 1'b0 || s_ready !== 1'b1 || empty !== 1'b1 || count !== 9'd0) begin
            fails++;
            $display("FAIL run_entry: got clr=%0b%0b s_ready=%0b empty=%0b count=%0d want 00/1/1/0",
                     fifo_wrptrclr, fifo_rdptrclr, s_ready, empty, count);
        end
        cyc_pos();
    endtask

    task automatic test_latency();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 9'h1A5;
        cyc_neg();
        tests++;
        if (fifo_wren !== 1'b1 || fifo_wrinc !== 1'b1 || fifo_din !== 9'h1A5) begin
            fails++;
            $display("FAIL lat_write: got wren=%0b wrinc=%0b din=%0h want 1/1/1a5", fifo_wren, fifo_wrinc, fifo_din);
        end
        cyc_pos();
        s_valid = 1'b0;
        cyc_neg();
        tests++;
        if (fifo_rden !== 1'b1 || fifo_rdinc !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_read: got rden=%0b rdinc=%0b m_valid=%0b want 1/1/0", fifo_rden, fifo_rdinc, m_valid);
        end
        cyc_pos();
        cyc_neg();
        tests++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_early: got m_valid=%0b want 0 at cycle 2", m_valid);
        end
        cyc_pos();
        cyc_neg();
        tests++;
        if (m_valid !== 1'b1 || m_data !== 9'h1A5) begin
            fails++;
            $display("FAIL lat_out: got m_valid=%0b m_data=%0h want 1/1a5 at cycle 3", m_valid, m_data);
        end
        cyc_pos();
        cyc_neg();
        tests++;
        if (count !== 9'd0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_done: got count=%0d m_valid=%0b want 0/0", count, m_valid);
        end
        cyc_pos();
    endtask

    task automatic test_full();
        int rej;
        rej = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 258; i++) begin
            s_valid = 1'b1;
            s_data  = DW'($urandom);
            cyc_neg();
            if (s_ready !== 1'b1) rej++;
            cyc_pos();
        end
        s_valid = 1'b0;
        tests++;
        if (rej != 0) begin
            fails++;
            $display("FAIL fill_accept: got %0d rejected want 0", rej);
        end
        repeat (3) step();
        cyc_neg();
        tests++;
        if (full !== 1'b1 || s_ready !== 1'b0 || count !== 9'd258 || m_valid !== 1'b1) begin
            fails++;
            $display("FAIL full_state: got full=%0b s_ready=%0b count=%0d m_valid=%0b want 1/0/258/1", full, s_ready, count, m_valid);
        end
        cyc_pos();
        s_valid = 1'b1;
        s_data  = DW'($urandom);
        cyc_neg();
        tests++;
        if (fifo_wren !== 1'b0) begin
            fails++;
            $display("FAIL full_block: got wren=%0b want 0", fifo_wren);
        end
        cyc_pos();
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc_neg();
        tests++;
        if (m_valid !== 1'b1 || fifo_rden !== 1'b1) begin
            fails++;
            $display("FAIL full_pop: got m_valid=%0b rden=%0b want 1/1", m_valid, fifo_rden);
        end
        cyc_pos();
        m_ready = 1'b0;
        cyc_neg();
        tests++;
        if (full !== 1'b0 || s_ready !== 1'b1 || count !== 9'd257) begin
            fails++;
            $display("FAIL after_pop: got full=%0b s_ready=%0b count=%0d want 0/1/257", full, s_ready, count);
        end
        cyc_pos();
        repeat (2) step();
        drain();
    endtask

    task automatic test_stream();
        int start, sent, first, last, n, stall;
        start = pop_cnt; sent = 0; first = -1; last = -1; n = 0; stall = 0;
        m_ready = 1'b1;
        while ((pop_cnt - start) < 600 && n < 2000) begin
            s_valid = (sent < 600);
            s_data  = DW'(sent);
            cyc_neg();
            if (sent < 600) begin
                if (s_ready) sent++;
                else stall++;
            end
            if (m_valid && m_ready) begin
                if (first < 0) first = cyc_cnt;
                last = cyc_cnt;
            end
            cyc_pos();
            n++;
        end
        s_valid = 1'b0;
        tests++;
        if ((pop_cnt - start) != 600 || stall != 0) begin
            fails++;
            $display("FAIL stream_count: got out=%0d stalls=%0d want 600/0", pop_cnt - start, stall);
        end
        tests++;
        if (last - first != 599) begin
            fails++;
            $display("FAIL stream_rate: got span=%0d want 599", last - first);
        end
        drain();
    endtask

    task automatic test_flush();
        logic [DW-1:0] w;
        bit got;
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_data  = DW'($urandom);
            step();
        end
        s_valid = 1'b0;
        repeat (3) step();
        m_ready = 1'b1;
        cyc_neg();
        tests++;
        if (fifo_rden !== 1'b1) begin
            fails++;
            $display("FAIL flush_setup: got rden=%0b want 1", fifo_rden);
        end
        cyc_pos();
        m_ready = 1'b0;
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = DW'($urandom);
        cyc_neg();
        tests++;
        if (fifo_wren !== 1'b0 || fifo_rden !== 1'b0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_suppress: got wren=%0b rden=%0b s_ready=%0b want 0/0/0", fifo_wren, fifo_rden, s_ready);
        end
        cyc_pos();
        flush   = 1'b0;
        s_valid = 1'b0;
        cyc_neg();
        tests++;
        if (fifo_wrptrclr !== 1'b1 || fifo_rdptrclr !== 1'b1 || count !== 9'd0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_state: got clr=%0b%0b count=%0d m_valid=%0b want 11/0/0", fifo_wrptrclr, fifo_rdptrclr, count, m_valid);
        end
        cyc_pos();
        w = DW'($urandom);
        s_valid = 1'b1;
        s_data  = w;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc_neg();
            if (m_valid && !got) begin
                got = 1'b1;
                tests++;
                if (m_data !== w) begin
                    fails++;
                    $display("FAIL flush_first: got %0h want %0h", m_data, w);
                end
            end
            cyc_pos();
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL flush_timeout: got no output want %0h", w);
        end
        drain();
    endtask

    task automatic test_rst_mid();
        traffic(60, 70, 40, 0);
        s_valid = 1'b1;
        s_data  = DW'($urandom);
        m_ready = 1'b1;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        s_valid = 1'b0;
        cyc_neg();
        tests++;
        if (fifo_wrptrclr !== 1'b1 || fifo_rdptrclr !== 1'b1 || s_ready !== 1'b0 || count !== 9'd0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_clr: got clr=%0b%0b s_ready=%0b count=%0d m_valid=%0b want 11/0/0/0",
                     fifo_wrptrclr, fifo_rdptrclr, s_ready, count, m_valid);
        end
        cyc_pos();
        cyc_neg();
        tests++;
        if (s_ready !== 1'b1 || empty !== 1'b1 || count !== 9'd0 || fifo_wrptrclr !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_run: got s_ready=%0b empty=%0b count=%0d clr=%0b want 1/1/0/0", s_ready, empty, count, fifo_wrptrclr);
        end
        cyc_pos();
        repeat (5) step();
        traffic(100, 60, 60, 0);
        drain();
    endtask

    task automatic test_random();
        traffic(1000, 60, 80, 5);
        traffic(1000, 80, 30, 3);
        traffic(1000, 40, 90, 5);
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full();
        test_stream();
        test_flush();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
